// File: rtl/vscale_hpm_counter_bank.sv
// HPM counter bank on the CSR port. The overflow interrupt is built only with VSCALE_HPM_OVF_IRQ_EN.
// Reads are combinational, writes land on the next edge, and an event reaches its count after 2 edges. There is no backpressure.
module vscale_hpm_counter_bank #(
    parameter int N_COUNTERS = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int N_EVENTS   = 8,
    parameter int SEL_W      = $clog2(N_EVENTS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [11:0]         addr,
    input  logic [2:0]          cmd,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                defined,
    input  logic [N_EVENTS-1:0] events,
    output logic                ovf_irq
);
    localparam int HI_W = CNT_WIDTH - 32;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [11:0] ADDR_LO  = 12'hB03;
    localparam logic [11:0] ADDR_HI  = 12'hB83;
    localparam logic [11:0] ADDR_SEL = 12'h323;
    localparam logic [11:0] ADDR_INH = 12'h320;

    logic [CNT_WIDTH-1:0]  cnt [N_COUNTERS];
    logic [SEL_W-1:0]      sel [N_COUNTERS];
    logic [N_COUNTERS-1:0] inh;
    logic [N_EVENTS-1:0]   ev_q;

    logic [N_COUNTERS-1:0] hit_lo;
    logic [N_COUNTERS-1:0] hit_hi;
    logic [N_COUNTERS-1:0] hit_sel;
    logic                  hit_inh;
    logic                  wen;
    logic [31:0]           wval;
    logic                  sel_legal;
    logic [SEL_W-1:0]      sel_wval;
    logic [N_COUNTERS-1:0] inc;
    logic [N_COUNTERS-1:0] wr_cnt;

`ifdef VSCALE_HPM_OVF_IRQ_EN
    localparam logic [11:0] ADDR_OVS = 12'h7C0;
    localparam logic [11:0] ADDR_OVE = 12'h7C1;

    logic                  hit_ovs;
    logic                  hit_ove;
    logic [N_COUNTERS-1:0] ovf;
    logic [N_COUNTERS-1:0] ovf_ie;
    logic [N_COUNTERS-1:0] wrap;
`endif

    always_comb begin
        hit_lo  = '0;
        hit_hi  = '0;
        hit_sel = '0;
        hit_inh = (addr == ADDR_INH);
        for (int i = 0; i < N_COUNTERS; i++) begin
            hit_lo[i]  = (addr == ADDR_LO  + 12'(i));
            hit_hi[i]  = (addr == ADDR_HI  + 12'(i));
            hit_sel[i] = (addr == ADDR_SEL + 12'(i));
        end
`ifdef VSCALE_HPM_OVF_IRQ_EN
        hit_ovs = (addr == ADDR_OVS);
        hit_ove = (addr == ADDR_OVE);
`endif
    end

    always_comb begin
        rdata   = '0;
        defined = (|hit_lo) | (|hit_hi) | (|hit_sel) | hit_inh;
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (hit_lo[i])  rdata = cnt[i][31:0];
            if (hit_hi[i])  rdata = 32'(cnt[i][CNT_WIDTH-1:32]);
            if (hit_sel[i]) rdata = 32'(sel[i]);
        end
        if (hit_inh) rdata = 32'(inh) << 3;
`ifdef VSCALE_HPM_OVF_IRQ_EN
        defined = defined | hit_ovs | hit_ove;
        if (hit_ovs) rdata = 32'(ovf);
        if (hit_ove) rdata = 32'(ovf_ie);
`endif
    end

    // SET/CLEAR are read-modify-write against the value currently decoded on rdata.
    always_comb begin
        wen = cmd[1] | cmd[0];
        casez (cmd)
            3'b?01:  wval = wdata;
            3'b?10:  wval = rdata | wdata;
            3'b?11:  wval = rdata & ~wdata;
            default: wval = wdata;
        endcase
        sel_legal = (wval <= 32'(N_EVENTS)) && ((wval >> SEL_W) == 32'd0);
        sel_wval  = sel_legal ? wval[SEL_W-1:0] : '0;
    end

    always_comb begin
        inc    = '0;
        wr_cnt = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            for (int e = 0; e < N_EVENTS; e++) begin
                if ((int'(sel[i]) == e + 1) && ev_q[e]) inc[i] = 1'b1;
            end
            inc[i]    = inc[i] & ~inh[i];
            wr_cnt[i] = wen & (hit_lo[i] | hit_hi[i]);
        end
    end

    // A software write to either half takes priority over the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_COUNTERS; i++) begin
                cnt[i] <= '0;
                sel[i] <= '0;
            end
            inh  <= '0;
            ev_q <= '0;
        end else begin
            ev_q <= events;
            if (wen && hit_inh) inh <= wval[N_COUNTERS+2:3];
            for (int i = 0; i < N_COUNTERS; i++) begin
                if (wen && hit_sel[i]) sel[i] <= sel_wval;
                if (wen && hit_lo[i]) begin
                    cnt[i][31:0] <= wval;
                end else if (wen && hit_hi[i]) begin
                    cnt[i][CNT_WIDTH-1:32] <= wval[HI_W-1:0];
                end else if (inc[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef VSCALE_HPM_OVF_IRQ_EN
    always_comb begin
        for (int i = 0; i < N_COUNTERS; i++) begin
            wrap[i] = inc[i] & ~wr_cnt[i] & (&cnt[i]);
        end
    end

    // Hardware-set overflow bits are ORed in after a status write so none is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf     <= '0;
            ovf_ie  <= '0;
            ovf_irq <= 1'b0;
        end else begin
            if (wen && hit_ovs) ovf <= wval[N_COUNTERS-1:0] | wrap;
            else                ovf <= ovf | wrap;
            if (wen && hit_ove) ovf_ie <= wval[N_COUNTERS-1:0];
            ovf_irq <= |(ovf & ovf_ie);
        end
    end
`else
    logic unused_wr_cnt;
    assign unused_wr_cnt = |wr_cnt;
    assign ovf_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_vscale_hpm_counter_bank.sv
// Directed bench for vscale_hpm_counter_bank; expectations follow VSCALE_HPM_OVF_IRQ_EN.
module tb_vscale_hpm_counter_bank;
    localparam logic [2:0] CSR_IDLE  = 3'd0;
    localparam logic [2:0] CSR_WRITE = 3'd5;
    localparam logic [2:0] CSR_SET   = 3'd6;
    localparam logic [2:0] CSR_CLEAR = 3'd7;

`ifdef VSCALE_HPM_OVF_IRQ_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] addr;
    logic [2:0]  cmd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        defined;
    logic [7:0]  events;
    logic        ovf_irq;

    int n_assert = 0;
    int n_fail   = 0;

    vscale_hpm_counter_bank dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .cmd     (cmd),
        .wdata   (wdata),
        .rdata   (rdata),
        .defined (defined),
        .events  (events),
        .ovf_irq (ovf_irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic def(input string tag, input logic [11:0] a, input logic exp);
        addr = a;
        #1;
        chk(tag, 32'(defined), 32'(exp));
    endtask

    task automatic csr(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d);
        addr  = a;
        cmd   = c;
        wdata = d;
        tick();
        cmd = CSR_IDLE;
    endtask

    initial begin
        reset  = 1'b1;
        addr   = 12'h000;
        cmd    = CSR_IDLE;
        wdata  = 32'h0;
        events = 8'h00;
        tick();
        tick();
        rd("rst_lo0", 12'hB03, 32'h0);
        rd("rst_hi0", 12'hB83, 32'h0);
        def("rst_def_lo0", 12'hB03, 1'b1);
        chk("rst_irq", 32'(ovf_irq), 32'h0);
        reset = 1'b0;
        tick();

        // WARL event select
        csr(CSR_WRITE, 12'h323, 32'd9);
        rd("warl_9", 12'h323, 32'd0);
        csr(CSR_WRITE, 12'h323, 32'd8);
        rd("warl_8", 12'h323, 32'd8);
        csr(CSR_WRITE, 12'h323, 32'h11);
        rd("warl_17", 12'h323, 32'd0);

        // event latency: 5 cycles of events[0]
        csr(CSR_WRITE, 12'h323, 32'd1);
        events = 8'h01;
        tick();
        rd("lat_e1", 12'hB03, 32'd0);
        tick();
        rd("lat_e2", 12'hB03, 32'd1);
        tick();
        tick();
        tick();
        events = 8'h00;
        rd("lat_e5", 12'hB03, 32'd4);
        tick();
        rd("lat_e6", 12'hB03, 32'd5);
        tick();
        rd("lat_e7", 12'hB03, 32'd5);

        // inhibit
        csr(CSR_WRITE, 12'hB03, 32'd0);
        csr(CSR_WRITE, 12'h320, 32'h8);
        rd("inh_rd", 12'h320, 32'h8);
        events = 8'h01;
        repeat (5) tick();
        events = 8'h00;
        tick();
        tick();
        rd("inh_cnt", 12'hB03, 32'd0);
        csr(CSR_WRITE, 12'h320, 32'hFFFF_FFFF);
        rd("inh_mask", 12'h320, 32'h78);
        csr(CSR_WRITE, 12'h320, 32'h0);

        // write beats increment
        events = 8'h01;
        tick();
        tick();
        csr(CSR_WRITE, 12'hB03, 32'h100);
        rd("prio_wr", 12'hB03, 32'h100);
        tick();
        rd("prio_inc", 12'hB03, 32'h101);
        rd("prio_hi", 12'hB83, 32'h0);
        events = 8'h00;
        repeat (3) tick();

        // SET/CLEAR and a write with cmd[2] clear
        csr(CSR_SET, 12'hB83, 32'h5);
        rd("set_hi", 12'hB83, 32'h5);
        csr(CSR_CLEAR, 12'hB83, 32'h4);
        rd("clr_hi", 12'hB83, 32'h1);
        csr(CSR_WRITE, 12'hB83, 32'h0);
        csr(3'b001, 12'h324, 32'd2);
        rd("cmd001_sel1", 12'h324, 32'd2);

        // wrap and interrupt on counter 1
        csr(CSR_WRITE, 12'hB04, 32'hFFFF_FFFF);
        csr(CSR_WRITE, 12'hB84, 32'hFFFF_FFFF);
        rd("wrap_pre_hi", 12'hB84, 32'hFFFF_FFFF);
        csr(CSR_WRITE, 12'h7C1, 32'hFFFF_FFFF);
        rd("ove_mask", 12'h7C1, OVF_ON ? 32'hF : 32'h0);
        def("ove_def", 12'h7C1, OVF_ON);
        csr(CSR_WRITE, 12'h7C1, 32'h2);
        events = 8'h02;
        tick();
        events = 8'h00;
        tick();
        rd("wrap_lo", 12'hB04, 32'h0);
        rd("wrap_hi", 12'hB84, 32'h0);
        rd("wrap_ovs", 12'h7C0, OVF_ON ? 32'h2 : 32'h0);
        chk("wrap_irq_e1", 32'(ovf_irq), 32'h0);
        tick();
        chk("wrap_irq_e2", 32'(ovf_irq), OVF_ON ? 32'h1 : 32'h0);
        csr(CSR_CLEAR, 12'h7C0, 32'h2);
        rd("ovs_clr", 12'h7C0, 32'h0);
        chk("clr_irq_e1", 32'(ovf_irq), OVF_ON ? 32'h1 : 32'h0);
        tick();
        chk("clr_irq_e2", 32'(ovf_irq), 32'h0);

        // CLEAR issued on the wrap cycle loses to the hardware set
        csr(CSR_WRITE, 12'hB04, 32'hFFFF_FFFF);
        csr(CSR_WRITE, 12'hB84, 32'hFFFF_FFFF);
        events = 8'h02;
        tick();
        events = 8'h00;
        csr(CSR_CLEAR, 12'h7C0, 32'h2);
        rd("race_ovs", 12'h7C0, OVF_ON ? 32'h2 : 32'h0);
        rd("race_lo", 12'hB04, 32'h0);
        def("race_def", 12'h7C0, OVF_ON);
        tick();
        tick();
        chk("race_irq", 32'(ovf_irq), OVF_ON ? 32'h1 : 32'h0);

        // counter write on the wrap cycle wins and raises no overflow
        csr(CSR_CLEAR, 12'h7C0, 32'hF);
        csr(CSR_WRITE, 12'hB04, 32'hFFFF_FFFF);
        csr(CSR_WRITE, 12'hB84, 32'hFFFF_FFFF);
        events = 8'h02;
        tick();
        events = 8'h00;
        csr(CSR_WRITE, 12'hB04, 32'h55);
        rd("wwrap_lo", 12'hB04, 32'h55);
        rd("wwrap_hi", 12'hB84, 32'hFFFF_FFFF);
        rd("wwrap_ovs", 12'h7C0, 32'h0);

        // unmapped addresses
        csr(CSR_WRITE, 12'h321, 32'hFFFF_FFFF);
        def("unm_321_def", 12'h321, 1'b0);
        rd("unm_321_rd", 12'h321, 32'h0);
        def("unm_b07_def", 12'hB07, 1'b0);
        def("unm_327_def", 12'h327, 1'b0);
        def("inh_def", 12'h320, 1'b1);
        rd("inh_untouched", 12'h320, 32'h0);

        // reset asserted mid-count with a write pending
        csr(CSR_WRITE, 12'h323, 32'd1);
        events = 8'h01;
        repeat (3) tick();
        addr  = 12'h324;
        cmd   = CSR_WRITE;
        wdata = 32'd5;
        reset = 1'b1;
        tick();
        cmd    = CSR_IDLE;
        events = 8'h00;
        rd("mrst_lo0", 12'hB03, 32'h0);
        rd("mrst_hi1", 12'hB84, 32'h0);
        rd("mrst_sel0", 12'h323, 32'h0);
        rd("mrst_sel1", 12'h324, 32'h0);
        rd("mrst_ove", 12'h7C1, 32'h0);
        chk("mrst_irq", 32'(ovf_irq), 32'h0);
        reset = 1'b0;
        tick();

        // counting resumes after reset
        csr(CSR_WRITE, 12'h323, 32'd1);
        events = 8'h01;
        tick();
        events = 8'h00;
        tick();
        rd("resume_lo0", 12'hB03, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
